lsu_unit: RTL and testbench

LSU_UNIT -- requirements
Module: lsu_unit

---
 rtl/lsu_unit.sv | 192 +++++++++++++++++++
 tb/tb_lsu_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_unit.sv
// ---------------------------------------------------------------------------
// lsu_unit -- load/store unit between the EX stage and a req/gnt/rvalid data
// bus. It accepts one access at a time and keeps at most one bus transaction
// outstanding.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   lsu_req_i           access request from EX (taken only when lsu_busy_o=0)
//   lsu_we_i            1=store, 0=load
//   lsu_type_i          00=word, 01=half, 10=byte, 11=illegal
//   lsu_sign_ext_i      sign-extend (1) or zero-extend (0) sub-word loads
//   lsu_addr_i          byte address
//   lsu_wdata_i         right-aligned store data
//   lsu_busy_o          access outstanding
//   rf_wdata_lsu_o      formatted load data (0 unless rf_we_lsu_o)
//   rf_we_lsu_o         one-cycle load writeback strobe
//   lsu_err_o           one-cycle error strobe (misaligned/illegal/bus error)
//   data_req_o          bus request, held until data_gnt_i
//   data_gnt_i          bus grant
//   data_we_o, data_be_o, data_addr_o, data_wdata_o   bus command fields
//   data_rvalid_i, data_err_i, data_rdata_i           bus response
//
// Handshake: a bus command is transferred in the cycle where data_req_o and
// data_gnt_i are both 1; the command fields are held stable from the first
// cycle of data_req_o until that cycle. The response is the single cycle in
// which data_rvalid_i=1 while waiting for it; responses at other times are
// ignored.
// ---------------------------------------------------------------------------
module lsu_unit (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_busy_o,
    output logic [31:0] rf_wdata_lsu_o,
    output logic        rf_we_lsu_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT_RV = 2'd2;

    localparam logic [1:0] T_WORD = 2'b00;
    localparam logic [1:0] T_HALF = 2'b01;
    localparam logic [1:0] T_BYTE = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [1:0]  type_q, type_d;
    logic        sign_q, sign_d;
    logic        rf_we_q, rf_we_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        err_q, err_d;

    logic        req_legal;
    logic [3:0]  req_be;
    logic [31:0] rdata_shifted;
    logic [31:0] load_fmt;

    // Alignment check on the incoming request.
    always_comb begin
        req_legal = 1'b0;
        case (lsu_type_i)
            T_WORD:  req_legal = (lsu_addr_i[1:0] == 2'b00);
            T_HALF:  req_legal = ~lsu_addr_i[0];
            T_BYTE:  req_legal = 1'b1;
            default: req_legal = 1'b0;
        endcase
    end

    always_comb begin
        req_be = 4'b1111;
        case (lsu_type_i)
            T_HALF:  req_be = 4'b0011 << lsu_addr_i[1:0];
            T_BYTE:  req_be = 4'b0001 << lsu_addr_i[1:0];
            default: req_be = 4'b1111;
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend per captured type.
    assign rdata_shifted = data_rdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_fmt = rdata_shifted;
        case (type_q)
            T_HALF:  load_fmt = {{16{sign_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
            T_BYTE:  load_fmt = {{24{sign_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
            default: load_fmt = rdata_shifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        type_d     = type_q;
        sign_d     = sign_q;
        rf_we_d    = 1'b0;
        rf_wdata_d = 32'h0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lsu_req_i) begin
                    if (req_legal) begin
                        addr_d  = lsu_addr_i;
                        be_d    = req_be;
                        wdata_d = lsu_wdata_i << {lsu_addr_i[1:0], 3'b000};
                        we_d    = lsu_we_i;
                        type_d  = lsu_type_i;
                        sign_d  = lsu_sign_ext_i;
                        state_d = S_REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (data_gnt_i) begin
                    state_d = S_WAIT_RV;
                end
            end
            S_WAIT_RV: begin
                if (data_rvalid_i) begin
                    state_d = S_IDLE;
                    if (data_err_i) begin
                        err_d = 1'b1;
                    end else if (!we_q) begin
                        rf_we_d    = 1'b1;
                        rf_wdata_d = load_fmt;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'h0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            we_q       <= 1'b0;
            type_q     <= 2'b00;
            sign_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_wdata_q <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            type_q     <= type_d;
            sign_q     <= sign_d;
            rf_we_q    <= rf_we_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    assign lsu_busy_o     = (state_q != S_IDLE);
    assign data_req_o     = (state_q == S_REQ);
    assign data_we_o      = we_q;
    assign data_be_o      = be_q;
    assign data_addr_o    = {addr_q[31:2], 2'b00};
    assign data_wdata_o   = wdata_q;
    assign rf_we_lsu_o    = rf_we_q;
    assign rf_wdata_lsu_o = rf_wdata_q;
    assign lsu_err_o      = err_q;

endmodule

// File: tb/tb_lsu_unit.sv
// ---------------------------------------------------------------------------
// tb_lsu_unit -- directed, table-driven bench for lsu_unit plus hand-written
// sequences for reset-abort and back-to-back loads.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, i.e. away from the edge.
// ---------------------------------------------------------------------------
module tb_lsu_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [1:0]  lsu_type_i = 2'b00;
    logic        lsu_sign_ext_i = 1'b0;
    logic [31:0] lsu_addr_i = 32'h0;
    logic [31:0] lsu_wdata_i = 32'h0;
    logic        lsu_busy_o;
    logic [31:0] rf_wdata_lsu_o;
    logic        rf_we_lsu_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_gnt_i = 1'b0;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i = 1'b0;
    logic        data_err_i = 1'b0;
    logic [31:0] data_rdata_i = 32'h0;

    int checks = 0;
    int errors = 0;

    lsu_unit dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .lsu_req_i      (lsu_req_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_type_i     (lsu_type_i),
        .lsu_sign_ext_i (lsu_sign_ext_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .lsu_busy_o     (lsu_busy_o),
        .rf_wdata_lsu_o (rf_wdata_lsu_o),
        .rf_we_lsu_o    (rf_we_lsu_o),
        .lsu_err_o      (lsu_err_o),
        .data_req_o     (data_req_o),
        .data_gnt_i     (data_gnt_i),
        .data_we_o      (data_we_o),
        .data_be_o      (data_be_o),
        .data_addr_o    (data_addr_o),
        .data_wdata_o   (data_wdata_o),
        .data_rvalid_i  (data_rvalid_i),
        .data_err_i     (data_err_i),
        .data_rdata_i   (data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Field order: we, typ, sgn, addr, wdata, dly, rdata, rerr,
    //              legal, be, eaddr, ewdata, erf_we, erf, eerr
    typedef struct {
        logic        we;
        logic [1:0]  typ;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rdata;
        logic        rerr;
        logic        legal;
        logic [3:0]  be;
        logic [31:0] eaddr;
        logic [31:0] ewdata;
        logic        erf_we;
        logic [31:0] erf;
        logic        eerr;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        lsu_req_i      = 1'b1;
        lsu_we_i       = v.we;
        lsu_type_i     = v.typ;
        lsu_sign_ext_i = v.sgn;
        lsu_addr_i     = v.addr;
        lsu_wdata_i    = v.wdata;
        step();
        lsu_req_i = 1'b0;
        if (!v.legal) begin
            chk({tag, " ill_req"},  {31'h0, data_req_o}, 32'h0);
            chk({tag, " ill_busy"}, {31'h0, lsu_busy_o}, 32'h0);
            chk({tag, " ill_err"},  {31'h0, lsu_err_o},  32'h1);
            chk({tag, " ill_rfwe"}, {31'h0, rf_we_lsu_o}, 32'h0);
            step();
            chk({tag, " ill_err_1cyc"}, {31'h0, lsu_err_o}, 32'h0);
            chk({tag, " ill_busy2"},    {31'h0, lsu_busy_o}, 32'h0);
            return;
        end
        chk({tag, " req"},   {31'h0, data_req_o}, 32'h1);
        chk({tag, " busy"},  {31'h0, lsu_busy_o}, 32'h1);
        chk({tag, " we"},    {31'h0, data_we_o},  {31'h0, v.we});
        chk({tag, " be"},    {28'h0, data_be_o},  {28'h0, v.be});
        chk({tag, " addr"},  data_addr_o,  v.eaddr);
        chk({tag, " wdata"}, data_wdata_o, v.ewdata);
        // Stall the grant; a stray rvalid here must not move the FSM.
        for (int i = 0; i < v.dly; i++) begin
            data_rvalid_i = 1'b1;
            step();
            data_rvalid_i = 1'b0;
            chk({tag, " req_held"},  {31'h0, data_req_o}, 32'h1);
            chk({tag, " addr_held"}, data_addr_o, v.eaddr);
            chk({tag, " be_held"},   {28'h0, data_be_o}, {28'h0, v.be});
        end
        data_gnt_i = 1'b1;
        step();
        data_gnt_i = 1'b0;
        chk({tag, " req_drop"}, {31'h0, data_req_o}, 32'h0);
        chk({tag, " busy_w"},   {31'h0, lsu_busy_o}, 32'h1);
        data_rvalid_i = 1'b1;
        data_err_i    = v.rerr;
        data_rdata_i  = v.rdata;
        step();
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        data_rdata_i  = 32'h0;
        chk({tag, " rf_we"},    {31'h0, rf_we_lsu_o}, {31'h0, v.erf_we});
        chk({tag, " rf_wdata"}, rf_wdata_lsu_o, v.erf);
        chk({tag, " err"},      {31'h0, lsu_err_o},   {31'h0, v.eerr});
        chk({tag, " idle"},     {31'h0, lsu_busy_o},  32'h0);
        step();
        chk({tag, " rf_we_1cyc"}, {31'h0, rf_we_lsu_o}, 32'h0);
        chk({tag, " rf_wdata_0"}, rf_wdata_lsu_o, 32'h0);
        chk({tag, " err_1cyc"},   {31'h0, lsu_err_o},   32'h0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 2'b10, 1'b1, 32'h1003, 32'h0, 0, 32'h80FF_0000, 1'b0,
                     1'b1, 4'b1000, 32'h1000, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0};
        vecs[1]  = '{1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000_BEEF, 3, 32'h0, 1'b0,
                     1'b1, 4'b1100, 32'h2000, 32'hBEEF_0000, 1'b0, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h3001, 32'h0, 0, 32'h0, 1'b0,
                     1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h4000, 32'h0, 0, 32'h1111_1111, 1'b1,
                     1'b1, 4'b1111, 32'h4000, 32'h0, 1'b0, 32'h0, 1'b1};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h5000, 32'h0, 2, 32'hDEAD_BEEF, 1'b0,
                     1'b1, 4'b1111, 32'h5000, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h6001, 32'h0, 0, 32'h0000_A500, 1'b0,
                     1'b1, 4'b0010, 32'h6000, 32'h0, 1'b1, 32'h0000_00A5, 1'b0};
        vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h7002, 32'h0, 1, 32'h9ABC_0000, 1'b0,
                     1'b1, 4'b1100, 32'h7000, 32'h0, 1'b1, 32'hFFFF_9ABC, 1'b0};
        vecs[7]  = '{1'b0, 2'b11, 1'b0, 32'h8000, 32'h0, 0, 32'h0, 1'b0,
                     1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1};
        vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h9001, 32'h0, 0, 32'h0, 1'b0,
                     1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1};
        vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'hA002, 32'h1234_5677, 0, 32'h0, 1'b0,
                     1'b1, 4'b0100, 32'hA000, 32'h5677_0000, 1'b0, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 2'b01, 1'b1, 32'h0000, 32'h0, 0, 32'h0000_7FFF, 1'b0,
                     1'b1, 4'b0011, 32'h0000, 32'h0, 1'b1, 32'h0000_7FFF, 1'b0};
        vecs[11] = '{1'b1, 2'b00, 1'b0, 32'hB000, 32'hCAFE_F00D, 1, 32'h0, 1'b0,
                     1'b1, 4'b1111, 32'hB000, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0};

        // Reset state.
        step();
        step();
        chk("rst busy",  {31'h0, lsu_busy_o},  32'h0);
        chk("rst req",   {31'h0, data_req_o},  32'h0);
        chk("rst rf_we", {31'h0, rf_we_lsu_o}, 32'h0);
        chk("rst err",   {31'h0, lsu_err_o},   32'h0);
        chk("rst addr",  data_addr_o, 32'h0);
        chk("rst be",    {28'h0, data_be_o}, 32'h0);
        rst_ni = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset while waiting for the response; a late rvalid must be ignored.
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 2'b00;
        lsu_sign_ext_i = 1'b0; lsu_addr_i = 32'hC004; lsu_wdata_i = 32'h0;
        step();
        lsu_req_i = 1'b0;
        data_gnt_i = 1'b1;
        step();
        data_gnt_i = 1'b0;
        chk("abort busy_pre", {31'h0, lsu_busy_o}, 32'h1);
        rst_ni = 1'b0;
        #1;
        chk("abort busy",  {31'h0, lsu_busy_o},  32'h0);
        chk("abort req",   {31'h0, data_req_o},  32'h0);
        chk("abort addr",  data_addr_o, 32'h0);
        chk("abort be",    {28'h0, data_be_o}, 32'h0);
        chk("abort rf_we", {31'h0, rf_we_lsu_o}, 32'h0);
        chk("abort err",   {31'h0, lsu_err_o},   32'h0);
        step();
        rst_ni = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h5555_AAAA;
        step();
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;
        chk("late_rv rf_we", {31'h0, rf_we_lsu_o}, 32'h0);
        chk("late_rv busy",  {31'h0, lsu_busy_o},  32'h0);
        step();
        chk("late_rv rf_we2", {31'h0, rf_we_lsu_o}, 32'h0);
        chk("late_rv err",    {31'h0, lsu_err_o},   32'h0);
        run_vec(vecs[5], 100);

        // Back-to-back zero-extended half loads; second accept during writeback.
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 2'b01;
        lsu_sign_ext_i = 1'b0; lsu_addr_i = 32'h0;
        step();
        lsu_req_i = 1'b0;
        data_gnt_i = 1'b1;
        step();
        data_gnt_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_8765;
        step();
        data_rvalid_i = 1'b0;
        chk("b2b rf_we1",    {31'h0, rf_we_lsu_o}, 32'h1);
        chk("b2b rf_wdata1", rf_wdata_lsu_o, 32'h0000_8765);
        lsu_req_i = 1'b1; lsu_addr_i = 32'h2;
        step();
        lsu_req_i = 1'b0;
        chk("b2b req2",  {31'h0, data_req_o}, 32'h1);
        chk("b2b be2",   {28'h0, data_be_o}, 32'h0000_000C);
        chk("b2b addr2", data_addr_o, 32'h0);
        data_gnt_i = 1'b1;
        step();
        data_gnt_i = 1'b0;
        data_rvalid_i = 1'b1;
        step();
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;
        chk("b2b rf_we2",    {31'h0, rf_we_lsu_o}, 32'h1);
        chk("b2b rf_wdata2", rf_wdata_lsu_o, 32'h0000_1234);
        step();
        chk("b2b idle", {31'h0, lsu_busy_o}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
